// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides, flag set, illegal-opcode flag
// and an optional shift-add multiplier (one operation in flight at a time).
`timescale 1ns/1ps
module alu_pipe #(
  parameter int N      = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         zero,
  output logic         carry,
  output logic         overflow,
  output logic         negative,
  output logic         illegal_op
);
  localparam int SW = $clog2(N);

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_XOR = 4'b0011, OP_SUB = 4'b0110, OP_SLT = 4'b0111,
                         OP_SLL = 4'b1000, OP_SRL = 4'b1001, OP_SRA = 4'b1010,
                         OP_NOR = 4'b1100, OP_MUL = 4'b1101;

  typedef enum logic {IDLE, MUL} state_t;

  typedef struct packed {
    logic [N-1:0] res;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         negative;
    logic         illegal;
  } resp_t;

  state_t       state;
  resp_t        rsp_d, rsp_q;
  logic [N-1:0] mcand, mplier, acc, acc_next;
  logic [SW-1:0] cnt;
  logic         accept, is_mul;
  logic [SW-1:0] shamt;
  logic [N:0]   sum_add, sum_sub;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (op == OP_MUL);
  assign shamt    = in_b[SW-1:0];
  assign sum_add  = {1'b0, in_a} + {1'b0, in_b};
  assign sum_sub  = {1'b0, in_a} + {1'b0, ~in_b} + {{N{1'b0}}, 1'b1};
  assign acc_next = mplier[0] ? acc + mcand : acc;

  // Single-cycle result. MUL lands in default (illegal) here; with MUL_EN=1
  // the FSM path below takes precedence, with MUL_EN=0 it is a genuine illegal op.
  always_comb begin
    rsp_d = '0;
    case (op)
      OP_AND: rsp_d.res = in_a & in_b;
      OP_OR:  rsp_d.res = in_a | in_b;
      OP_XOR: rsp_d.res = in_a ^ in_b;
      OP_NOR: rsp_d.res = ~(in_a | in_b);
      OP_ADD: begin
        rsp_d.res      = sum_add[N-1:0];
        rsp_d.carry    = sum_add[N];
        rsp_d.overflow = (in_a[N-1] == in_b[N-1]) && (sum_add[N-1] != in_a[N-1]);
      end
      OP_SUB: begin
        rsp_d.res      = sum_sub[N-1:0];
        rsp_d.carry    = sum_sub[N];
        rsp_d.overflow = (in_a[N-1] == ~in_b[N-1]) && (sum_sub[N-1] != in_a[N-1]);
      end
      OP_SLT: rsp_d.res = {{(N-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      OP_SLL: rsp_d.res = in_a << shamt;
      OP_SRL: rsp_d.res = in_a >> shamt;
      OP_SRA: rsp_d.res = $signed(in_a) >>> shamt;
      default: rsp_d.illegal = 1'b1;
    endcase
    rsp_d.zero     = (rsp_d.res == '0);
    rsp_d.negative = rsp_d.res[N-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      rsp_q     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state     <= MUL;
              mcand     <= in_a;
              mplier    <= in_b;
              acc       <= '0;
              cnt       <= SW'(N-1);
              out_valid <= 1'b0;
            end else begin
              rsp_q     <= rsp_d;
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - SW'(1);
          // Output register is guaranteed free here: MUL only starts when it is.
          if (cnt == '0) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            rsp_q     <= '{res: acc_next, zero: (acc_next == '0), carry: 1'b0,
                           overflow: 1'b0, negative: acc_next[N-1], illegal: 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out        = rsp_q.res;
  assign zero       = rsp_q.zero;
  assign carry      = rsp_q.carry;
  assign overflow   = rsp_q.overflow;
  assign negative   = rsp_q.negative;
  assign illegal_op = rsp_q.illegal;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors from the block's rules plus
// randomized ops checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_pipe;
  localparam int N = 32;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] op = '0;
  logic [N-1:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, zero, carry, overflow, negative, illegal_op;
  logic [N-1:0] out;

  logic in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic [3:0] op2 = '0;
  logic [N-1:0] a2 = '0, b2 = '0;
  logic in_ready2, out_valid2, zero2, carry2, overflow2, negative2, illegal2;
  logic [N-1:0] out2;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_pipe #(.N(N), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero(zero), .carry(carry), .overflow(overflow), .negative(negative),
    .illegal_op(illegal_op));

  alu_pipe #(.N(N), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .op(op2),
    .in_a(a2), .in_b(b2), .out_valid(out_valid2), .out_ready(out_ready2), .out(out2),
    .zero(zero2), .carry(carry2), .overflow(overflow2), .negative(negative2),
    .illegal_op(illegal2));

  // Expected {out, zero, carry, overflow, negative, illegal_op}
  function automatic logic [N+4:0] model(input logic [3:0] o, input logic [N-1:0] a, b);
    logic [N-1:0] r;
    bit c, v, il;
    longint sa, sb, ex;
    int sh;
    r = '0; c = 0; v = 0; il = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    case (o)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd3:  r = a ^ b;
      4'd12: r = ~(a | b);
      4'd2: begin
        r = a + b;
        c = ((64'(a) + 64'(b)) >> 32) != 0;
        ex = sa + sb;
        v = (ex > MAXI) || (ex < MINI);
      end
      4'd6: begin
        r = a - b;
        c = (a >= b);
        ex = sa - sb;
        v = (ex > MAXI) || (ex < MINI);
      end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: r = 32'(sa >>> sh);
      4'd13: r = 32'(64'(a) * 64'(b));
      default: il = 1;
    endcase
    return {r, r == 0, c, v, r[N-1], il};
  endfunction

  function automatic logic [N-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [3:0] rnd_single_op();
    logic [3:0] o;
    o = 4'($urandom_range(0, 15));
    if (o == 4'd13) o = 4'd2;
    return o;
  endfunction

  // Present one op and hold it until accepted (bounded); returns #1 after accept edge.
  task automatic send(input logic [3:0] o, input logic [N-1:0] a, b, output bit ok);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; op = o; in_a = a; in_b = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 200);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid (bounded).
  task automatic wait_out(output bit ok, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    bit ok;
    #1;
    n_cmp++;
    if ({out_valid, out, zero, carry, overflow, negative, illegal_op} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b out=%h flags=%b%b%b%b%b, want all 0",
               out_valid, out, zero, carry, overflow, negative, illegal_op);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    // Result held (out_ready=0), then async reset between edges must clear it at once.
    out_ready = 1'b0;
    send(4'd2, 32'd3, 32'd4, ok);
    n_cmp++;
    if (!ok || out_valid !== 1'b1 || out !== 32'd7) begin
      n_bad++;
      $display("FAIL reset_pre_add: got ok=%b valid=%b out=%h, want 1/1/7", ok, out_valid, out);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out, zero, carry, overflow, negative, illegal_op} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got valid=%b out=%h, want 0/0", out_valid, out);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got in_ready=%b, want 1", in_ready);
    end
  endtask

  logic [3:0]   d_op  [14] = '{4'h2, 4'h2, 4'h6, 4'h7, 4'hA, 4'h9, 4'h5, 4'hF,
                               4'h8, 4'hC, 4'h0, 4'h3, 4'h6, 4'h6};
  logic [N-1:0] d_a   [14] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'h8000_0000, 32'h123, 32'h1,
                               32'h1, 32'h0, 32'hF0F0, 32'hFFFF, 32'h0, 32'h8000_0000};
  logic [N-1:0] d_b   [14] = '{32'd1, 32'd1, 32'd5, 32'd1, 32'h104, 32'h104, 32'h456,
                               32'h2, 32'h21, 32'h0, 32'hFF00, 32'hFFFF, 32'h1, 32'h1};
  logic [N+4:0] d_exp [14] = '{{32'h8000_0000, 5'b00110}, {32'h0, 5'b11000},
                               {32'h0, 5'b11000}, {32'h1, 5'b00000},
                               {32'hF800_0000, 5'b00010}, {32'h0800_0000, 5'b00000},
                               {32'h0, 5'b10001}, {32'h0, 5'b10001},
                               {32'h2, 5'b00000}, {32'hFFFF_FFFF, 5'b00010},
                               {32'hF000, 5'b00000}, {32'h0, 5'b10000},
                               {32'hFFFF_FFFF, 5'b00010}, {32'h7FFF_FFFF, 5'b01100}};

  task automatic test_directed();
    bit ok;
    logic [N+4:0] got;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(d_op[i], d_a[i], d_b[i], ok);
      got = {out, zero, carry, overflow, negative, illegal_op};
      n_cmp++;
      if (!ok || out_valid !== 1'b1 || got !== d_exp[i]) begin
        n_bad++;
        $display("FAIL directed_%0d op=%h: got valid=%b {out,zcvni}=%h, want %h",
                 i, d_op[i], out_valid, got, d_exp[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok, ok2;
    int lat;
    logic [3:0] o;
    logic [N-1:0] a, b;
    logic [N+4:0] exp, got;
    out_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      a = rnd_operand();
      b = rnd_operand();
      exp = model(o, a, b);
      send(o, a, b, ok);
      wait_out(ok2, lat);
      got = {out, zero, carry, overflow, negative, illegal_op};
      n_cmp++;
      if (!ok || !ok2 || got !== exp) begin
        n_bad++;
        $display("FAIL random_%0d op=%h a=%h b=%h: got %h, want %h", i, o, a, b, got, exp);
      end
      n_cmp++;
      if (lat != ((o == 4'd13) ? N : 0)) begin
        n_bad++;
        $display("FAIL random_lat_%0d op=%h: got %0d, want %0d", i, o, lat,
                 (o == 4'd13) ? N : 0);
      end
    end
  endtask

  task automatic test_mul_backpressure();
    bit ok, busy_bad, late;
    int lat;
    logic [N+4:0] got;
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    send(4'hD, 32'd12345, 32'd6789, ok);
    lat = 0; busy_bad = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0) busy_bad = 1;
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (!ok || lat != N) begin
      n_bad++;
      $display("FAIL mul_latency: got %0d cycles (accepted=%b), want %0d", lat, ok, N);
    end
    n_cmp++;
    if (busy_bad) begin
      n_bad++;
      $display("FAIL mul_busy_ready: in_ready seen 1 during MUL, want 0");
    end
    got = {out, zero, carry, overflow, negative, illegal_op};
    n_cmp++;
    if (got !== {32'd83810205, 5'b00000}) begin
      n_bad++;
      $display("FAIL mul_result: got %h, want %h", got, {32'd83810205, 5'b00000});
    end
    // Backpressure: a pending request must not be taken and the result must hold.
    @(negedge clk);
    in_valid = 1'b1; op = 4'h2; in_a = 32'd1; in_b = 32'd1;
    repeat (5) begin
      @(posedge clk); #1;
      got = {out, zero, carry, overflow, negative, illegal_op};
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== {32'd83810205, 5'b00000}) begin
        n_bad++;
        $display("FAIL mul_hold: got valid=%b ready=%b %h, want 1/0 %h",
                 out_valid, in_ready, got, {32'd83810205, 5'b00000});
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mul_retire: got out_valid=%b, want 0", out_valid);
    end
    // Reset part way through a multiply: no result may ever appear.
    send(4'hD, rnd_operand(), rnd_operand(), ok);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    late = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) late = 1;
    end
    n_cmp++;
    if (!ok || late || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mul_reset_abort: got accepted=%b late_result=%b in_ready=%b, want 1/0/1",
               ok, late, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [N+4:0] q[$];
    logic [N+4:0] exp, got;
    logic [3:0] o;
    logic [N-1:0] a, b;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      o = rnd_single_op(); a = rnd_operand(); b = rnd_operand();
      in_valid = 1'b1; op = o; in_a = a; in_b = b;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_ready_%0d: got in_ready=%b, want 1", i, in_ready);
      end
      q.push_back(model(o, a, b));
      @(posedge clk); #1;
      exp = q.pop_front();
      got = {out, zero, carry, overflow, negative, illegal_op};
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp) begin
        n_bad++;
        $display("FAIL b2b_result_%0d op=%h: got valid=%b %h, want %h", i, o, out_valid, got, exp);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drain: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_mul_disabled();
    logic [N+4:0] got, exp;
    @(negedge clk);
    in_valid2 = 1'b1; op2 = 4'hD; a2 = 32'd7; b2 = 32'd9;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    got = {out2, zero2, carry2, overflow2, negative2, illegal2};
    n_cmp++;
    if (out_valid2 !== 1'b1 || got !== {32'h0, 5'b10001}) begin
      n_bad++;
      $display("FAIL nomul_illegal: got valid=%b %h, want 1 %h", out_valid2, got, {32'h0, 5'b10001});
    end
    @(negedge clk);
    in_valid2 = 1'b1; op2 = 4'h6; a2 = rnd_operand(); b2 = rnd_operand();
    exp = model(op2, a2, b2);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    got = {out2, zero2, carry2, overflow2, negative2, illegal2};
    n_cmp++;
    if (out_valid2 !== 1'b1 || got !== exp) begin
      n_bad++;
      $display("FAIL nomul_sub: got valid=%b %h, want 1 %h", out_valid2, got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mul_backpressure();
    test_back_to_back();
    test_mul_disabled();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's combinational 4-bit-opcode ALU.
- Keeps the existing opcode encodings and adds XOR, shifts and an iterative multiply.
- Adds a valid/ready handshake on both sides, a registered result with a flag set, and an illegal-opcode indication.
- Sits between the decode/issue stage and writeback; one operation in flight at a time.

Parameters:
- N, 32, operand and result width in bits (N >= 4, power of two).
- MUL_EN, 1, 1 enables opcode 1101 (MUL); 0 makes 1101 illegal and removes the multiplier datapath.
- SW (localparam), $clog2(N), shift-amount width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept an operation this cycle
- op  input  4  opcode
- in_a  input  N  operand A
- in_b  input  N  operand B
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- out  output  N  result
- zero  output  1  out == 0
- carry  output  1  ADD carry-out / SUB not-borrow; 0 for all other ops
- overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops
- negative  output  1  out[N-1]
- illegal_op  output  1  accepted opcode was not legal

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0, out=0, all flags=0; in_ready=1 after release. Reset mid-multiply abandons the operation; no result is ever presented.
- Accept: a transfer occurs when in_valid && in_ready on a clock edge. op/in_a/in_b are sampled only then.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at full rate while the consumer is ready.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR
  - 0110 SUB (A-B); 0111 SLT: signed, out={N-1 zeros, A<B}
  - 1000 SLL, 1001 SRL, 1010 SRA: shift A by in_b[SW-1:0]; upper bits of in_b are ignored
  - 1100 NOR; 1101 MUL: low N bits of unsigned A*B
  - All others are illegal.
- Illegal op: completes as a single-cycle op with out=0, zero=1, illegal_op=1, and other flags 0. Never X.
- Arithmetic: ADD/SUB are computed N+1 bits wide. carry = bit N of the A+B or A+~B+1 sum. overflow = (sign A == sign of B-operand after inversion for SUB) && (sign result != sign A). SLT uses the signed compare directly, not the subtractor sign.
- Latency, single-cycle ops: out/flags are registered on the accept edge; out_valid=1 the following cycle.
- FSM states: IDLE, MUL.
  - IDLE + accept of MUL (MUL_EN=1) -> MUL; load multiplicand=A, multiplier=B, acc=0, cnt=N-1.
  - MUL: each cycle, if multiplier[0] then acc+=multiplicand (mod 2^N); then multiplicand<<=1, multiplier>>=1, cnt--.
  - When the cnt==0 iteration completes -> IDLE and out_valid=1 with out=acc. Total latency is exactly N cycles from accept to out_valid.
  - For MUL: zero and negative are from the result; carry=overflow=0.
  - in_ready=0 throughout MUL.
  - A MUL can only start when the output register is free, so the result never waits on a full register.
- Output hold: while out_valid && !out_ready, out and all flags hold stable and nothing new is accepted.
- Simultaneous out_ready and new accept in the same cycle: the old result retires and the new one is loaded, so out_valid stays 1.
- out_valid drops the cycle after out_ready if there is no new accept.
- Flags (zero, carry, overflow, negative, illegal_op) are registered with out and are valid only while out_valid=1.

Test Plan:
- Reset/idle: assert rst_n=0 mid-run -> out_valid=0, out=0, flags=0 immediately (asynchronous); after release in_ready=1.
- ADD overflow (N=32): A=32'h7FFF_FFFF, B=1, op=0010 -> next cycle out=32'h8000_0000, overflow=1, negative=1, carry=0, zero=0. Then A=32'hFFFF_FFFF, B=1 -> out=0, carry=1, zero=1, overflow=0.
- SUB/SLT: op=0110, A=5, B=5 -> out=0, zero=1, carry=1. Then op=0111, A=32'hFFFF_FFFF (-1), B=1 -> out=1.
- Shifts: op=1010, A=32'h8000_0000, B=32'h0000_0104 -> shift 4, out=32'hF800_0000. Same operands with op=1001 -> 32'h0800_0000.
- MUL latency/backpressure: op=1101, A=12345, B=6789 -> in_ready=0 for 32 cycles, then out_valid=1, out=83810205. With out_ready held 0 for 5 cycles, out is stable and in_ready=0. A reset pulse during an in-progress MUL produces no result.
- Throughput/illegal: stream 8 back-to-back ops with out_ready=1 -> one result per cycle, in order. Opcode 0101 -> out=0, zero=1, illegal_op=1. With MUL_EN=0, opcode 1101 -> illegal_op=1 with single-cycle latency.
